multi_debouncer: RTL

MULTI_DEBOUNCER -- requirements
Module: multi_debouncer

---
 rtl/debounce_pkg.sv | 14 +
 rtl/debounce_channel.sv | 76 +++++++
 rtl/multi_debouncer.sv | 53 +++++
 3 files changed

// File: rtl/debounce_pkg.sv
// debounce_pkg: repeat FSM state type and width helper shared by the debouncer files
package debounce_pkg;

    typedef enum logic [1:0] {IDLE, HOLD, REPEAT} rpt_state_t;

    // Bits needed to hold values 0..n-1, never less than one
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: one button - synchroniser, stability counter and auto-repeat FSM
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int STABLE_COUNT = 8,
    parameter bit ACTIVE_LOW   = 1'b0,
    parameter int HOLD_TICKS   = 500,
    parameter int RPT_TICKS    = 100
) (
    input  logic clk,
    input  logic clr_n,
    input  logic tick,
    input  logic raw,
    input  logic rpt_en,
    output logic state,
    output logic press,
    output logic rel,
    output logic rpt
);

    localparam int SW = clog2(STABLE_COUNT + 1);
    localparam int RW = clog2(HOLD_TICKS > RPT_TICKS ? HOLD_TICKS : RPT_TICKS);

    logic [1:0]    sync;
    logic [SW-1:0] stab;
    logic [RW-1:0] rcnt, rcnt_nx;
    rpt_state_t    rs, rs_nx;
    logic          rpt_nx, flip;

    assign flip = tick && (sync[1] != state) && (stab == SW'(STABLE_COUNT - 1));

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            sync  <= '0;
            stab  <= '0;
            state <= 1'b0;
            press <= 1'b0;
            rel   <= 1'b0;
            rs    <= IDLE;
            rcnt  <= '0;
            rpt   <= 1'b0;
        end else begin
            sync  <= {sync[0], raw ^ ACTIVE_LOW};
            press <= flip && !state;
            rel   <= flip && state;
            state <= state ^ flip;
            if (tick) stab <= (sync[1] == state || flip) ? '0 : stab + 1'b1;
            rs    <= rs_nx;
            rcnt  <= rcnt_nx;
            rpt   <= rpt_nx;
        end
    end

    // In HOLD/REPEAT the level is 1, so a flip there is always the release
    always_comb begin
        rs_nx   = rs;
        rcnt_nx = rcnt;
        rpt_nx  = 1'b0;
        unique case (rs)
            IDLE: if (flip && !state && rpt_en) begin
                rs_nx   = HOLD;
                rcnt_nx = '0;
            end
            HOLD, REPEAT: if (!rpt_en || !state || flip) rs_nx = IDLE;
                else if (tick) begin
                    if (rcnt == (rs == HOLD ? RW'(HOLD_TICKS - 1) : RW'(RPT_TICKS - 1))) begin
                        rs_nx   = REPEAT;
                        rcnt_nx = '0;
                        rpt_nx  = 1'b1;
                    end else rcnt_nx = rcnt + 1'b1;
                end
            default: rs_nx = IDLE;
        endcase
    end

endmodule

// File: rtl/multi_debouncer.sv
// multi_debouncer: shared sample prescaler feeding CHANNELS independent button debouncers
module multi_debouncer
    import debounce_pkg::*;
#(
    parameter int CHANNELS     = 4,
    parameter int SAMPLE_DIV   = 250000,
    parameter int STABLE_COUNT = 8,
    parameter bit ACTIVE_LOW   = 1'b0,
    parameter int HOLD_TICKS   = 500,
    parameter int RPT_TICKS    = 100
) (
    input  logic                clk,
    input  logic                clr_n,
    input  logic [CHANNELS-1:0] btn_in,
    input  logic [CHANNELS-1:0] rpt_en,
    output logic [CHANNELS-1:0] btn_state,
    output logic [CHANNELS-1:0] btn_press,
    output logic [CHANNELS-1:0] btn_release,
    output logic [CHANNELS-1:0] btn_rpt
);

    localparam int PW = clog2(SAMPLE_DIV);

    logic [PW-1:0] pre;
    logic          tick;

    assign tick = (pre == PW'(SAMPLE_DIV - 1));

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) pre <= '0;
        else pre <= tick ? '0 : pre + 1'b1;
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        debounce_channel #(
            .STABLE_COUNT(STABLE_COUNT),
            .ACTIVE_LOW  (ACTIVE_LOW),
            .HOLD_TICKS  (HOLD_TICKS),
            .RPT_TICKS   (RPT_TICKS)
        ) u_ch (
            .clk   (clk),
            .clr_n (clr_n),
            .tick  (tick),
            .raw   (btn_in[i]),
            .rpt_en(rpt_en[i]),
            .state (btn_state[i]),
            .press (btn_press[i]),
            .rel   (btn_release[i]),
            .rpt   (btn_rpt[i])
        );
    end

endmodule
